cache_line_refill: RTL and testbench
====================================

// Module: cache_line_refill
// PURPOSE
//   Refill engine on the write side of the cache data MEMORY. On a miss it requests the line
//   from the next level, accepts beats in critical-word-first wrapped order and drives the
//   memory write port, one word per accepted beat.
//   It forwards the critical word to the pipeline and signals completion once the line is in memory.
// PARAMETERS
//   DATA_WIDTH     32   word width; matches the data memory
//   ADDR_WIDTH     32   word-address width of requests and of the memory port
//   DEPTH          512  data-memory depth in words; power of 2, multiple of LINE_WORDS
//   LINE_WORDS     8    words per cache line; power of 2, >=2. OFFSET_BITS = clog2(LINE_WORDS)
// PORTS
//   CLK            in   1           clock; all logic on posedge
//   RST            in   1           synchronous reset, active-high
//   REQ_VALID      in   1           miss request from the cache controller
//   REQ_READY      out  1           high only in IDLE
//   REQ_ADDR       in   ADDR_WIDTH  word address of the missing (critical) word
//   MEM_ADDR_VALID out  1           line request to the next level
//   MEM_ADDR_READY in   1           next level accepts the request
//   MEM_ADDR       out  ADDR_WIDTH  critical-word address, registered REQ_ADDR
//   MEM_DATA_VALID in   1           beat valid
//   MEM_DATA_READY out  1           high only in FILL
//   MEM_DATA       in   DATA_WIDTH  beat data
//   PORTA_WREN     out  1           data-memory write enable
//   PORTA_WADDR    out  ADDR_WIDTH  data-memory write address
//   PORTA_DATA_IN  out  DATA_WIDTH  data-memory write data
//   CRIT_VALID     out  1           one-cycle pulse: critical word available
//   CRIT_DATA      out  DATA_WIDTH  critical word; held until the next CRIT_VALID
//   FILL_DONE      out  1           one-cycle pulse: the whole line is committed
//   BUSY           out  1           state != IDLE
// BEHAVIOUR
//   FSM: IDLE -> ADDR on REQ_VALID&REQ_READY; latch REQ_ADDR, start_off = REQ_ADDR[OFFSET_BITS-1:0].
//     ADDR: MEM_ADDR_VALID=1, MEM_ADDR stable; -> FILL on MEM_ADDR_READY.
//     FILL: beat accepted when MEM_DATA_VALID&MEM_DATA_READY; beat counter cnt 0..LINE_WORDS-1.
//       -> DONE when the beat with cnt==LINE_WORDS-1 is accepted.
//     DONE: one cycle; -> IDLE. FILL_DONE is a registered pulse in the first IDLE cycle.
//   Write pipeline, one registered stage: beat accepted at edge E -> PORTA_WREN=1 with
//     WADDR/DATA_IN valid for the cycle after E; memory commits at edge E+1.
//     Gaps in MEM_DATA_VALID produce no writes.
//   Address: word offset = (start_off + cnt) mod LINE_WORDS (wraps within the line).
//     PORTA_WADDR = zero-extended {REQ_ADDR[clog2(DEPTH)-1:OFFSET_BITS], offset}.
//     REQ_ADDR bits above clog2(DEPTH) go to MEM_ADDR only.
//   CRIT_VALID pulses in the same cycle as the cnt==0 write. CRIT_DATA = that beat.
//   FILL_DONE is high in the cycle after the final write commits. REQ_READY is also high then,
//     so a back-to-back request is legal in that cycle.
//   REQ_VALID is ignored while BUSY. MEM_DATA_VALID is ignored outside FILL.
//     Exactly LINE_WORDS writes per fill.
//   Reset values: all outputs 0 except REQ_READY=1. State IDLE, counters 0.
//   Reset mid-operation: next cycle returns to IDLE and drops any pending write (PORTA_WREN=0).
//     No FILL_DONE. Partially written line contents are left as-is; the controller must not mark the line valid.
// TESTING
//   1 RST high 2 cycles -> all outputs 0, REQ_READY=1, BUSY=0.
//   2 REQ_ADDR=0x40, ADDR_READY immediate, 8 back-to-back beats 0xA0..0xA7
//       -> writes 0x40..0x47 = 0xA0..0xA7.
//       -> CRIT_VALID with CRIT_DATA=0xA0 on the first write; FILL_DONE one cycle after the last commit.
//   3 REQ_ADDR=0x45, beats 0xB0..0xB7 -> MEM_ADDR=0x45.
//       -> writes 0x45,46,47,40,41,42,43,44 = 0xB0..0xB7; CRIT_DATA=0xB0.
//   4 MEM_ADDR_READY low 3 cycles, then DATA_VALID every other cycle
//       -> MEM_ADDR held stable, exactly 8 writes, none in gap cycles.
//   5 REQ_VALID with REQ_ADDR=0x80 during FILL -> ignored (REQ_READY=0).
//       -> accepted in the FILL_DONE cycle, then fills 0x80..0x87.
//   6 RST after 3 beats of fill 0x40 -> no further writes, no FILL_DONE.
//       -> REQ_READY=1 the next cycle; a new fill of 0x40 then completes correctly.

Source files
------------

// File: rtl/cache_line_refill_if.sv
// Refill engine bus bundle: miss request, next-level request/data channels,
// data-memory write port and pipeline notifications.
interface cache_line_refill_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic [ADDR_WIDTH-1:0] REQ_ADDR;
    logic                  MEM_ADDR_VALID;
    logic                  MEM_ADDR_READY;
    logic [ADDR_WIDTH-1:0] MEM_ADDR;
    logic                  MEM_DATA_VALID;
    logic                  MEM_DATA_READY;
    logic [DATA_WIDTH-1:0] MEM_DATA;
    logic                  PORTA_WREN;
    logic [ADDR_WIDTH-1:0] PORTA_WADDR;
    logic [DATA_WIDTH-1:0] PORTA_DATA_IN;
    logic                  CRIT_VALID;
    logic [DATA_WIDTH-1:0] CRIT_DATA;
    logic                  FILL_DONE;
    logic                  BUSY;

    // master: the refill engine itself
    modport master (
        input  REQ_VALID, REQ_ADDR, MEM_ADDR_READY, MEM_DATA_VALID, MEM_DATA,
        output REQ_READY, MEM_ADDR_VALID, MEM_ADDR, MEM_DATA_READY,
               PORTA_WREN, PORTA_WADDR, PORTA_DATA_IN, CRIT_VALID, CRIT_DATA,
               FILL_DONE, BUSY
    );

    // slave: cache controller / next level / data memory side
    modport slave (
        output REQ_VALID, REQ_ADDR, MEM_ADDR_READY, MEM_DATA_VALID, MEM_DATA,
        input  REQ_READY, MEM_ADDR_VALID, MEM_ADDR, MEM_DATA_READY,
               PORTA_WREN, PORTA_WADDR, PORTA_DATA_IN, CRIT_VALID, CRIT_DATA,
               FILL_DONE, BUSY
    );
endinterface

// File: rtl/cache_line_refill.sv
// Cache line refill engine: requests a missing line, writes critical-word-first
// wrapped beats into the data memory, forwards the critical word, flags completion.
module cache_line_refill #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 512,
    parameter int LINE_WORDS = 8
) (
    input logic                 CLK,
    input logic                 RST,
    cache_line_refill_if.master bus
);
    localparam int OFFSET_BITS = $clog2(LINE_WORDS);
    localparam int INDEX_BITS  = $clog2(DEPTH);
    localparam logic [OFFSET_BITS-1:0] LAST_BEAT = OFFSET_BITS'(LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]                        state;
    logic [ADDR_WIDTH-1:0]             req_addr;
    logic [OFFSET_BITS-1:0]            cnt;
    logic [OFFSET_BITS-1:0]            offset;
    logic [INDEX_BITS-OFFSET_BITS-1:0] line_idx;
    logic                              beat;
    logic                              wren;
    logic [ADDR_WIDTH-1:0]             waddr;
    logic [DATA_WIDTH-1:0]             wdata;
    logic                              crit_valid;
    logic [DATA_WIDTH-1:0]             crit_data;
    logic                              fill_done;

    assign beat     = (state == S_FILL) && bus.MEM_DATA_VALID;
    // Offset addition wraps modulo LINE_WORDS by truncation.
    assign offset   = req_addr[OFFSET_BITS-1:0] + cnt;
    assign line_idx = req_addr[INDEX_BITS-1:OFFSET_BITS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            req_addr   <= '0;
            cnt        <= '0;
            wren       <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
            fill_done  <= 1'b0;
        end else begin
            wren       <= beat;
            crit_valid <= beat && (cnt == '0);
            fill_done  <= (state == S_DONE);
            if (beat) begin
                waddr <= ADDR_WIDTH'({line_idx, offset});
                wdata <= bus.MEM_DATA;
                cnt   <= cnt + 1'b1;
                if (cnt == '0)
                    crit_data <= bus.MEM_DATA;
            end
            case (state)
                S_IDLE: if (bus.REQ_VALID) begin
                    req_addr <= bus.REQ_ADDR;
                    cnt      <= '0;
                    state    <= S_ADDR;
                end
                S_ADDR: if (bus.MEM_ADDR_READY) state <= S_FILL;
                S_FILL: if (beat && cnt == LAST_BEAT) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.REQ_READY      = (state == S_IDLE);
    assign bus.BUSY           = (state != S_IDLE);
    assign bus.MEM_ADDR_VALID = (state == S_ADDR);
    assign bus.MEM_ADDR       = req_addr;
    assign bus.MEM_DATA_READY = (state == S_FILL);
    assign bus.PORTA_WREN     = wren;
    assign bus.PORTA_WADDR    = waddr;
    assign bus.PORTA_DATA_IN  = wdata;
    assign bus.CRIT_VALID     = crit_valid;
    assign bus.CRIT_DATA      = crit_data;
    assign bus.FILL_DONE      = fill_done;
endmodule

// File: tb/tb_cache_line_refill.sv
// Directed + randomized bench for cache_line_refill against a line-wrap address model.
module tb_cache_line_refill;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 512;
    localparam int LW    = 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    cache_line_refill_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cache_line_refill #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LINE_WORDS(LW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Write/notification log, sampled mid-cycle.
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    int            wc_q[$];
    int            crit_n, crit_cyc, done_n;
    logic [DW-1:0] crit_d;

    always @(negedge CLK) begin
        if (bus.PORTA_WREN) begin
            wa_q.push_back(bus.PORTA_WADDR);
            wd_q.push_back(bus.PORTA_DATA_IN);
            wc_q.push_back(cyc);
        end
        if (bus.CRIT_VALID) begin
            crit_n++;
            crit_cyc = cyc;
            crit_d   = bus.CRIT_DATA;
        end
        if (bus.FILL_DONE) done_n++;
    end

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        crit_n = 0; done_n = 0; crit_cyc = -1; crit_d = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word k of a fill lands in the same line, offset rotated from the critical word.
    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a, input int k);
        int line_base, off;
        line_base = int'((a % DEPTH) / LW) * LW;
        off       = (int'(a % LW) + k) % LW;
        return AW'(line_base + off);
    endfunction

    // gap: 0 = back-to-back beats, 1 = every other cycle, 2 = random
    task automatic do_fill(input logic [AW-1:0] a, input int stall, input int gap,
                           input logic [DW-1:0] d0, input bit rnd_data,
                           input bit pre, input bit pend, input logic [AW-1:0] pend_a);
        logic [DW-1:0] beats[LW];
        int            acc[LW];
        int            k, budget, last_wc;
        bit            v;
        for (int i = 0; i < LW; i++) beats[i] = rnd_data ? DW'($urandom) : DW'(d0 + DW'(i));
        if (!pre) begin
            bus.REQ_VALID = 1'b1;
            bus.REQ_ADDR  = a;
            @(negedge CLK);
            chk("req_ready_idle", bus.REQ_READY, 1);
            @(posedge CLK); #1;
        end
        bus.REQ_VALID = 1'b0;
        clear_log();
        for (int s = 0; s <= stall; s++) begin
            bus.MEM_ADDR_READY = (s == stall);
            bus.MEM_DATA_VALID = 1'($urandom_range(0, 1));
            bus.MEM_DATA       = DW'($urandom);
            @(negedge CLK);
            chk("addr_valid", bus.MEM_ADDR_VALID, 1);
            chk("mem_addr", bus.MEM_ADDR, a);
            chk("data_ready_in_addr", bus.MEM_DATA_READY, 0);
            chk("busy", bus.BUSY, 1);
            @(posedge CLK); #1;
        end
        bus.MEM_ADDR_READY = 1'b0;
        if (pend) begin
            bus.REQ_VALID = 1'b1;
            bus.REQ_ADDR  = pend_a;
        end
        k = 0;
        budget = 0;
        while (k < LW && budget < 64) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? (budget % 2 == 0) : 1'($urandom_range(0, 1));
            bus.MEM_DATA_VALID = v;
            bus.MEM_DATA       = v ? beats[k] : DW'($urandom);
            @(negedge CLK);
            chk("data_ready_fill", bus.MEM_DATA_READY, 1);
            if (pend) chk("req_ready_busy", bus.REQ_READY, 0);
            if (v) begin
                acc[k] = cyc;
                k++;
            end
            @(posedge CLK); #1;
            budget++;
        end
        // Junk beats outside FILL must be ignored.
        bus.MEM_DATA_VALID = 1'b1;
        bus.MEM_DATA       = DW'($urandom);
        chk("beats_sent", k, LW);
        budget = 0;
        do begin
            @(negedge CLK);
            budget++;
        end while (!bus.FILL_DONE && budget < 20);
        chk("fill_done_seen", bus.FILL_DONE, 1);
        chk("ready_at_done", bus.REQ_READY, 1);
        chk("busy_at_done", bus.BUSY, 0);
        chk("n_writes", wa_q.size(), LW);
        for (int i = 0; i < LW && i < wa_q.size() && i < k; i++) begin
            chk("waddr", wa_q[i], exp_addr(a, i));
            chk("wdata", wd_q[i], beats[i]);
            chk("wcycle", wc_q[i], acc[i] + 1);
        end
        chk("crit_count", crit_n, 1);
        chk("crit_data", crit_d, beats[0]);
        if (k > 0) chk("crit_cycle", crit_cyc, acc[0] + 1);
        last_wc = (wc_q.size() > 0) ? wc_q[wc_q.size() - 1] : -10;
        chk("done_cycle", cyc, last_wc + 1);
        @(posedge CLK); #1;
        bus.REQ_VALID = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.REQ_VALID      = 1'b0;
        bus.REQ_ADDR       = '0;
        bus.MEM_ADDR_READY = 1'b0;
        bus.MEM_DATA_VALID = 1'b0;
        bus.MEM_DATA       = '0;
        clear_log();

        // reset state
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_ready", bus.REQ_READY, 1);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_addr_valid", bus.MEM_ADDR_VALID, 0);
        chk("rst_mem_addr", bus.MEM_ADDR, 0);
        chk("rst_data_ready", bus.MEM_DATA_READY, 0);
        chk("rst_wren", bus.PORTA_WREN, 0);
        chk("rst_waddr", bus.PORTA_WADDR, 0);
        chk("rst_wdata", bus.PORTA_DATA_IN, 0);
        chk("rst_crit_valid", bus.CRIT_VALID, 0);
        chk("rst_crit_data", bus.CRIT_DATA, 0);
        chk("rst_fill_done", bus.FILL_DONE, 0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // aligned line, back-to-back beats
        do_fill(32'h40, 0, 0, 32'hA0, 1'b0, 1'b0, 1'b0, '0);
        // wrapped line, critical word mid-line
        do_fill(32'h45, 0, 0, 32'hB0, 1'b0, 1'b0, 1'b0, '0);
        // address stall then beats every other cycle
        do_fill(32'h13B, 3, 1, 32'hC0, 1'b0, 1'b0, 1'b0, '0);
        // request held during fill, accepted in the FILL_DONE cycle
        do_fill(32'h40, 0, 0, 32'hD0, 1'b0, 1'b0, 1'b1, 32'h80);
        do_fill(32'h80, 0, 0, 32'hE0, 1'b0, 1'b1, 1'b0, '0);

        // reset after 3 beats
        bus.REQ_VALID = 1'b1;
        bus.REQ_ADDR  = 32'h40;
        @(posedge CLK); #1;
        bus.REQ_VALID      = 1'b0;
        bus.MEM_ADDR_READY = 1'b1;
        @(posedge CLK); #1;
        bus.MEM_ADDR_READY = 1'b0;
        bus.MEM_DATA_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.MEM_DATA = DW'(32'hF0 + i);
            @(posedge CLK); #1;
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        clear_log();
        @(negedge CLK);
        chk("abort_req_ready", bus.REQ_READY, 1);
        chk("abort_busy", bus.BUSY, 0);
        chk("abort_wren", bus.PORTA_WREN, 0);
        repeat (10) @(posedge CLK);
        #1;
        chk("abort_no_writes", wa_q.size(), 0);
        chk("abort_no_done", done_n, 0);
        do_fill(32'h40, 0, 0, 32'h50, 1'b0, 1'b0, 1'b0, '0);

        // randomized fills, including address bits above the memory index
        repeat (4) do_fill(AW'($urandom), $urandom_range(0, 3), 2, '0, 1'b1, 1'b0, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
